led_array_top: RTL and testbench

LED_ARRAY_TOP -- requirements
Module: led_array_top

---
 rtl/led_array_top.sv | 85 ++++++++
 tb/tb_led_array_top.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/led_array_top.sv
// Serial-loaded 32-bit LED register: 32-bit MSB-first frames carry an 8-bit command and 24-bit data.
// The frame executes on its last clock edge, and a combinational enable gates the LED drive.
module led_array_top #(
  parameter int FRAME_BITS = 32
) (
  input  logic        i_SPI_CLK,
  input  logic        i_RESET_p,
  input  logic        i_SPI_ENA_n,
  input  logic        i_SPI_DATA,
  input  logic        i_ENA_p,
  output logic [31:0] o_LED
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic [CNT_W-1:0]      bit_cnt_r;
  logic [FRAME_BITS-2:0] shift_r;
  logic [31:0]           led_r;
  logic [31:0]           led_next_s;
  logic [FRAME_BITS-1:0] frame_s;
  logic                  frame_done_s;

  function automatic logic [31:0] decode_cmd(input logic [31:0] led,
                                             input logic [7:0]  cmd,
                                             input logic [23:0] dat);
    logic [31:0] res;
    res = led;
    case (cmd)
      8'h00:   res = led;
      8'h01:   res[23:0]  = dat;
      8'h02:   res[31:24] = dat[7:0];
      8'h03:   res[23:0]  = led[23:0] | dat;
      8'h04:   res[23:0]  = led[23:0] & ~dat;
      8'h05:   res[23:0]  = led[23:0] ^ dat;
      8'h06:   res[31:24] = led[31:24] | dat[7:0];
      8'h07:   res[31:24] = led[31:24] & ~dat[7:0];
      8'hFF:   res = 32'h0000_0000;
      default: res = led;
    endcase
    return res;
  endfunction

  // Bit counter: deselect clears it asynchronously so an aborted frame never lingers.
  always_ff @(posedge i_SPI_CLK or posedge i_RESET_p or posedge i_SPI_ENA_n) begin
    if (i_RESET_p || i_SPI_ENA_n) begin
      bit_cnt_r <= '0;
    end else begin
      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
    end
  end

  // Shift register: holds its contents while deselected.
  always_ff @(posedge i_SPI_CLK or posedge i_RESET_p) begin
    if (i_RESET_p) begin
      shift_r <= '0;
    end else if (!i_SPI_ENA_n) begin
      shift_r <= {shift_r[FRAME_BITS-3:0], i_SPI_DATA};
    end
  end

  // The last data bit is taken straight from the pin so the command runs on the same edge.
  always_comb begin
    frame_s      = {shift_r, i_SPI_DATA};
    frame_done_s = 1'b0;
    led_next_s   = decode_cmd(led_r, frame_s[31:24], frame_s[23:0]);
    if (!i_SPI_ENA_n && (bit_cnt_r == LAST_BIT)) begin
      frame_done_s = 1'b1;
    end else begin
      frame_done_s = 1'b0;
    end
  end

  // LED register update.
  always_ff @(posedge i_SPI_CLK or posedge i_RESET_p) begin
    if (i_RESET_p) begin
      led_r <= 32'h0000_0000;
    end else if (frame_done_s) begin
      led_r <= led_next_s;
    end
  end

  assign o_LED = i_ENA_p ? led_r : 32'h0000_0000;

endmodule

// File: tb/tb_led_array_top.sv
// Directed-vector bench for led_array_top; stimulus pushes expected LED values into a queue
// and an independent monitor pops and compares them against o_LED on the falling clock edge.
module tb_led_array_top;

  logic        clk;
  logic        rst;
  logic        spi_ena_n;
  logic        spi_data;
  logic        ena_p;
  logic [31:0] o_led;

  logic [31:0] exp_q[$];
  int          tag_q[$];
  int          n_cmp;
  int          n_bad;

  led_array_top #(.FRAME_BITS(32)) dut (
    .i_SPI_CLK  (clk),
    .i_RESET_p  (rst),
    .i_SPI_ENA_n(spi_ena_n),
    .i_SPI_DATA (spi_data),
    .i_ENA_p    (ena_p),
    .o_LED      (o_led)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Monitor: compares one queued expectation per falling edge.
  always @(negedge clk) begin
    logic [31:0] e;
    int          t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (o_led !== e) begin
        n_bad++;
        $display("FAIL led_step%0d: got %08h expected %08h", t, o_led, e);
      end
    end
  end

  task automatic expect_led(input int tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
    #1;
  endtask

  // Shifts the top nbits of w, MSB first; returns just after the last rising edge.
  task automatic shift_word(input logic [31:0] w, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) begin
      @(negedge clk);
      spi_ena_n = 1'b0;
      spi_data  = w[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    @(negedge clk);
    spi_ena_n = 1'b1;
    spi_data  = 1'($urandom_range(1, 0));
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] w);
    shift_word(w, 32);
    end_frame();
  endtask

  logic [31:0] sweep_cmd [9];
  logic [31:0] sweep_exp [9];

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    spi_ena_n = 1'b1;
    spi_data  = 1'b0;
    ena_p     = 1'b1;

    sweep_cmd = '{32'h01ABCDEF, 32'h0200005A, 32'h040000EF, 32'h05FFFFFF, 32'h070000F0,
                  32'h06000081, 32'h00FFFFFF, 32'h42123456, 32'hFF000000};
    sweep_exp = '{32'h00ABCDEF, 32'h5AABCDEF, 32'h5AABCD00, 32'h5A5432FF, 32'h0A5432FF,
                  32'h8B5432FF, 32'h8B5432FF, 32'h8B5432FF, 32'h00000000};

    // Reset pulse with output enabled
    repeat (3) @(posedge clk);
    #1;
    expect_led(1, 32'h0000_0000);
    drain();
    rst = 1'b0;
    expect_led(2, 32'h0000_0000);
    drain();

    // Enable gating; command still executes while disabled
    ena_p = 1'b0;
    send_frame(32'h03000100);
    expect_led(3, 32'h0000_0000);
    drain();
    ena_p = 1'b1;
    expect_led(4, 32'h0000_0100);
    drain();
    ena_p = 1'b0;
    expect_led(5, 32'h0000_0000);
    drain();
    ena_p = 1'b1;

    // Command sweep, each step applied to the previous result
    for (int i = 0; i < 9; i++) begin
      send_frame(sweep_cmd[i]);
      expect_led(10 + i, sweep_exp[i]);
      drain();
    end

    // Seed a value, then abort a partial frame
    send_frame(32'h01000055);
    expect_led(20, 32'h0000_0055);
    drain();
    shift_word(32'h01FFFFFF, 16);
    end_frame();
    expect_led(21, 32'h0000_0055);
    drain();

    // Back-to-back frames under one select; first result checked mid-burst
    shift_word(32'h01000001, 32);
    expect_led(22, 32'h0000_0001);
    shift_word(32'h03000002, 32);
    expect_led(23, 32'h0000_0003);
    end_frame();
    drain();

    // Reset mid-frame; clock edges during reset are ignored
    shift_word(32'h01FFFFFF, 20);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      spi_data = 1'(i);
    end
    #1;
    expect_led(24, 32'h0000_0000);
    drain();
    @(negedge clk);
    spi_ena_n = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(32'h01000010);
    expect_led(25, 32'h0000_0010);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
